// File: rtl/cdr_lf_seq.sv
// cdr_lf_seq: acquisition/tracking sequencer for the Rx CDR digital PI loop filter.
// Holds the filter off for a settle period, then steps the proportional gain
// from the highest gear down to the tracking gear. After that it watches the
// wrapped PI-code drift over fixed windows to declare lock, and goes back to
// acquisition when lock is lost.
// Optional feature: define CDR_LF_SEQ_TIMEOUT_EN to enable the acquisition
// timeout. The sequencer then enters FAIL after TIMEOUT_WIN consecutive failed
// lock windows in CHECK. When the macro is undefined, fail is tied low and
// CHECK retries forever.
module cdr_lf_seq #(
  parameter int PI_BIT      = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int ACQ_CYC     = 64,
  parameter int GEAR_CYC    = 32,
  parameter int NUM_GEARS   = 4,
  parameter int LOCK_WIN    = 64,
  parameter int LOCK_TOL    = 2,
  parameter int UNLOCK_TOL  = 6,
  parameter int TIMEOUT_WIN = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                en,
  input  logic [PI_BIT-1:0]                                   pi_code,
  output logic                                                filter_en,
  output logic [((NUM_GEARS > 1) ? $clog2(NUM_GEARS) : 1)-1:0] kp_sel,
  output logic                                                locked,
  output logic                                                lock_lost,
  output logic                                                fail,
  output logic [2:0]                                          state
);

  localparam int KP_W    = (NUM_GEARS > 1) ? $clog2(NUM_GEARS) : 1;
  localparam int ACC_W   = PI_BIT + $clog2(LOCK_WIN) + 1;
  localparam int MAX_A   = (SETTLE_CYC > ACQ_CYC) ? SETTLE_CYC : ACQ_CYC;
  localparam int MAX_B   = (GEAR_CYC > LOCK_WIN) ? GEAR_CYC : LOCK_WIN;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ACQ    = 3'd2,
    S_GEAR   = 3'd3,
    S_CHECK  = 3'd4,
    S_LOCKED = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [KP_W-1:0]           kp_sel_q, kp_sel_d;
  logic                      filter_en_q, filter_en_d;
  logic                      locked_q, locked_d;
  logic                      lock_lost_q, lock_lost_d;
  logic                      fail_q, fail_d;

  logic [PI_BIT-1:0]         pi_prev_q, pi_prev_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   acc_min_q, acc_min_d;
  logic signed [ACC_W-1:0]   acc_max_q, acc_max_d;
  logic signed [PI_BIT-1:0]  delta;
  logic signed [ACC_W-1:0]   span;
  logic                      meas_active;
  logic                      win_last;

`ifdef CDR_LF_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_WIN > 1) ? $clog2(TIMEOUT_WIN) : 1;
  logic [TW-1:0]             win_fail_q, win_fail_d;
`endif

  // Drift measurement: accumulate signed wrapped code deltas and track the
  // running min/max of the accumulator over each window.
  always_comb begin
    pi_prev_d   = pi_prev_q;
    acc_d       = acc_q;
    acc_min_d   = acc_min_q;
    acc_max_d   = acc_max_q;
    meas_active = (state_q == S_CHECK) || (state_q == S_LOCKED);
    delta       = pi_code - pi_prev_q;
    win_last    = (32'(cnt_q) == LOCK_WIN - 1);
    if (!en) begin
      pi_prev_d = '0;
      acc_d     = '0;
      acc_min_d = '0;
      acc_max_d = '0;
    end else if (meas_active) begin
      pi_prev_d = pi_code;
      if (cnt_q == '0) begin
        acc_d     = '0;
        acc_min_d = '0;
        acc_max_d = '0;
      end else begin
        acc_d     = acc_q + {{(ACC_W-PI_BIT){delta[PI_BIT-1]}}, delta};
        acc_min_d = (acc_d < acc_min_q) ? acc_d : acc_min_q;
        acc_max_d = (acc_d > acc_max_q) ? acc_d : acc_max_q;
      end
    end
    span = acc_max_d - acc_min_d;
  end

  // Next-state logic: cycle timing of settle/acquire/gear phases, window
  // decisions in CHECK/LOCKED, and registered output values from the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kp_sel_d    = kp_sel_q;
    lock_lost_d = 1'b0;
`ifdef CDR_LF_SEQ_TIMEOUT_EN
    win_fail_d  = win_fail_q;
`endif
    case (state_q)
      S_IDLE: begin
        kp_sel_d = '0;
        if (en) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        kp_sel_d = '0;
        if (32'(cnt_q) == SETTLE_CYC - 1) begin
          state_d = S_ACQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACQ: begin
        kp_sel_d = '0;
        if (32'(cnt_q) == ACQ_CYC - 1) begin
          cnt_d = '0;
          if (NUM_GEARS > 1) begin
            state_d  = S_GEAR;
            kp_sel_d = KP_W'(1);
          end else begin
            state_d = S_CHECK;
`ifdef CDR_LF_SEQ_TIMEOUT_EN
            win_fail_d = '0;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GEAR: begin
        if (32'(cnt_q) == GEAR_CYC - 1) begin
          cnt_d = '0;
          if (32'(kp_sel_q) == NUM_GEARS - 1) begin
            state_d = S_CHECK;
`ifdef CDR_LF_SEQ_TIMEOUT_EN
            win_fail_d = '0;
`endif
          end else begin
            kp_sel_d = kp_sel_q + KP_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (win_last) begin
          cnt_d = '0;
          if (span <= ACC_W'(LOCK_TOL)) begin
            state_d = S_LOCKED;
`ifdef CDR_LF_SEQ_TIMEOUT_EN
          end else if (32'(win_fail_q) == TIMEOUT_WIN - 1) begin
            state_d  = S_FAIL;
            kp_sel_d = '0;
          end else begin
            win_fail_d = win_fail_q + TW'(1);
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOCKED: begin
        if (win_last) begin
          cnt_d = '0;
          if (span > ACC_W'(UNLOCK_TOL)) begin
            state_d     = S_ACQ;
            kp_sel_d    = '0;
            lock_lost_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FAIL: begin
        kp_sel_d = '0;
        cnt_d    = '0;
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        kp_sel_d = '0;
      end
    endcase

    if (!en) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      kp_sel_d    = '0;
      lock_lost_d = 1'b0;
`ifdef CDR_LF_SEQ_TIMEOUT_EN
      win_fail_d  = '0;
`endif
    end

    filter_en_d = (state_d == S_ACQ) || (state_d == S_GEAR) ||
                  (state_d == S_CHECK) || (state_d == S_LOCKED);
    locked_d    = (state_d == S_LOCKED);
`ifdef CDR_LF_SEQ_TIMEOUT_EN
    fail_d      = (state_d == S_FAIL);
`else
    fail_d      = 1'b0;
`endif
  end

  // State, counters, measurement and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      kp_sel_q    <= '0;
      filter_en_q <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      fail_q      <= 1'b0;
      pi_prev_q   <= '0;
      acc_q       <= '0;
      acc_min_q   <= '0;
      acc_max_q   <= '0;
`ifdef CDR_LF_SEQ_TIMEOUT_EN
      win_fail_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kp_sel_q    <= kp_sel_d;
      filter_en_q <= filter_en_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      fail_q      <= fail_d;
      pi_prev_q   <= pi_prev_d;
      acc_q       <= acc_d;
      acc_min_q   <= acc_min_d;
      acc_max_q   <= acc_max_d;
`ifdef CDR_LF_SEQ_TIMEOUT_EN
      win_fail_q  <= win_fail_d;
`endif
    end
  end

  assign filter_en = filter_en_q;
  assign kp_sel    = kp_sel_q;
  assign locked    = locked_q;
  assign lock_lost = lock_lost_q;
  assign fail      = fail_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cdr_lf_seq.sv
// tb_cdr_lf_seq: self-checking bench for cdr_lf_seq with small parameters
// (8/4/8/8/3/16/2/6, TIMEOUT_WIN=3). Expected output vectors are queued per
// cycle and compared as the DUT reaches each cycle.
module tb_cdr_lf_seq;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_ACQ    = 3'd2;
  localparam logic [2:0] ST_GEAR   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_LOCKED = 3'd5;
  localparam logic [2:0] ST_FAIL   = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] pi_code = 8'h00;
  logic       filter_en;
  logic [1:0] kp_sel;
  logic       locked;
  logic       lock_lost;
  logic       fail;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       fe;
    logic [1:0] kp;
    logic       lk;
    logic       ll;
    logic       fl;
  } outv_t;

  typedef struct {
    int    cyc;
    outv_t v;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] tog6 [6] = '{8'd254, 8'd255, 8'd0, 8'd1, 8'd0, 8'd255};

  cdr_lf_seq #(
    .PI_BIT(8), .SETTLE_CYC(4), .ACQ_CYC(8), .GEAR_CYC(8), .NUM_GEARS(3),
    .LOCK_WIN(16), .LOCK_TOL(2), .UNLOCK_TOL(6), .TIMEOUT_WIN(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pi_code(pi_code),
    .filter_en(filter_en), .kp_sel(kp_sel), .locked(locked),
    .lock_lost(lock_lost), .fail(fail), .state(state)
  );

  always #5 clk = ~clk;

  function automatic outv_t mk(input logic [2:0] st, input logic fe, input logic [1:0] kp,
                               input logic lk, input logic ll, input logic fl);
    outv_t v;
    v.st = st; v.fe = fe; v.kp = kp; v.lk = lk; v.ll = ll; v.fl = fl;
    return v;
  endfunction

  function automatic outv_t observed();
    return {state, filter_en, kp_sel, locked, lock_lost, fail};
  endfunction

  task automatic push_exp(input int c, input outv_t v);
    exp_t x;
    x.cyc = c;
    x.v   = v;
    sb.push_back(x);
  endtask

  // Apply inputs for the current cycle, clock once, observe the next cycle.
  task automatic drive(input logic en_v, input logic [7:0] code);
    en      = en_v;
    pi_code = code;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic restart();
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc = 0;
    push_exp(1, mk(ST_IDLE, 0, 0, 0, 0, 0));
    push_exp(2, mk(ST_IDLE, 0, 0, 0, 0, 0));
    repeat (2) begin
      drive(1'b1, 8'($urandom));
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e.v) begin
          n_fail++;
          $display("[TB] FAIL reset cyc %0d: got %b required %b (st,fe,kp,lk,ll,fl)", cyc, observed(), e.v);
        end
      end
    end
  endtask

  task automatic test_acquire();
    restart();
    push_exp(1,  mk(ST_SETTLE, 0, 0, 0, 0, 0));
    push_exp(4,  mk(ST_SETTLE, 0, 0, 0, 0, 0));
    push_exp(5,  mk(ST_ACQ,    1, 0, 0, 0, 0));
    push_exp(12, mk(ST_ACQ,    1, 0, 0, 0, 0));
    push_exp(13, mk(ST_GEAR,   1, 1, 0, 0, 0));
    push_exp(20, mk(ST_GEAR,   1, 1, 0, 0, 0));
    push_exp(21, mk(ST_GEAR,   1, 2, 0, 0, 0));
    push_exp(28, mk(ST_GEAR,   1, 2, 0, 0, 0));
    push_exp(29, mk(ST_CHECK,  1, 2, 0, 0, 0));
    push_exp(44, mk(ST_CHECK,  1, 2, 0, 0, 0));
    push_exp(45, mk(ST_LOCKED, 1, 2, 1, 0, 0));
    push_exp(46, mk(ST_LOCKED, 1, 2, 1, 0, 0));
    while (cyc < 46) begin
      drive(1'b1, 8'h40);
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e.v) begin
          n_fail++;
          $display("[TB] FAIL acquire cyc %0d: got %b required %b (st,fe,kp,lk,ll,fl)", cyc, observed(), e.v);
        end
      end
    end
  endtask

  task automatic test_rst_locked();
    rst = 1'b1;
    push_exp(cyc + 1, mk(ST_IDLE, 0, 0, 0, 0, 0));
    drive(1'b1, 8'h40);
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (observed() !== e.v) begin
        n_fail++;
        $display("[TB] FAIL rst_locked cyc %0d: got %b required %b (st,fe,kp,lk,ll,fl)", cyc, observed(), e.v);
      end
    end
  endtask

  task automatic test_wrap_lock();
    logic [7:0] code;
    restart();
    push_exp(29, mk(ST_CHECK,  1, 2, 0, 0, 0));
    push_exp(45, mk(ST_CHECK,  1, 2, 0, 0, 0));
    push_exp(61, mk(ST_CHECK,  1, 2, 0, 0, 0));
    push_exp(76, mk(ST_CHECK,  1, 2, 0, 0, 0));
    push_exp(77, mk(ST_LOCKED, 1, 2, 1, 0, 0));
    while (cyc < 77) begin
      if (cyc < 29)
        code = 8'h00;
      else if (cyc < 61)
        code = tog6[(cyc - 29) % 6];
      else
        code = (((cyc - 61) % 2) == 0) ? 8'hff : 8'h00;
      drive(1'b1, code);
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e.v) begin
          n_fail++;
          $display("[TB] FAIL wrap_lock cyc %0d: got %b required %b (st,fe,kp,lk,ll,fl)", cyc, observed(), e.v);
        end
      end
    end
  endtask

  task automatic test_unlock();
    push_exp(92,  mk(ST_LOCKED, 1, 2, 1, 0, 0));
    push_exp(93,  mk(ST_ACQ,    1, 0, 0, 1, 0));
    push_exp(94,  mk(ST_ACQ,    1, 0, 0, 0, 0));
    push_exp(101, mk(ST_GEAR,   1, 1, 0, 0, 0));
    while (cyc < 101) begin
      drive(1'b1, 8'(cyc));
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e.v) begin
          n_fail++;
          $display("[TB] FAIL unlock cyc %0d: got %b required %b (st,fe,kp,lk,ll,fl)", cyc, observed(), e.v);
        end
      end
    end
  endtask

  task automatic test_en_drop();
    push_exp(cyc + 1, mk(ST_IDLE,   0, 0, 0, 0, 0));
    push_exp(cyc + 2, mk(ST_SETTLE, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      drive((i == 1), 8'h11);
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e.v) begin
          n_fail++;
          $display("[TB] FAIL en_drop cyc %0d: got %b required %b (st,fe,kp,lk,ll,fl)", cyc, observed(), e.v);
        end
      end
    end
  endtask

  task automatic test_timeout();
    restart();
    push_exp(29, mk(ST_CHECK, 1, 2, 0, 0, 0));
    push_exp(76, mk(ST_CHECK, 1, 2, 0, 0, 0));
`ifdef CDR_LF_SEQ_TIMEOUT_EN
    push_exp(77, mk(ST_FAIL,  0, 0, 0, 0, 1));
    push_exp(80, mk(ST_FAIL,  0, 0, 0, 0, 1));
`else
    push_exp(77, mk(ST_CHECK, 1, 2, 0, 0, 0));
    push_exp(80, mk(ST_CHECK, 1, 2, 0, 0, 0));
`endif
    push_exp(81, mk(ST_IDLE,  0, 0, 0, 0, 0));
    while (cyc < 81) begin
      drive((cyc < 80), 8'(cyc));
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e.v) begin
          n_fail++;
          $display("[TB] FAIL timeout cyc %0d: got %b required %b (st,fe,kp,lk,ll,fl)", cyc, observed(), e.v);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] cdr_lf_seq bench start");
    test_reset();
    test_acquire();
    test_rst_locked();
    test_wrap_lock();
    test_unlock();
    test_en_drop();
    test_timeout();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unreached cyc %0d: got no sample required %b", e.cyc, e.v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdr_lf_seq.md
Name: cdr_lf_seq

Overview:
Acquisition/tracking sequencer for the Rx CDR digital PI loop filter.
- Holds the filter in reset for a settle period, then enables it.
- Gear-shifts the proportional gain from high (fast acquisition) to low (tracking).
- Declares lock by watching the wrapped PI-code drift over a window, and re-acquires on loss of lock.
- Sits between the Rx link control and the loop filter: drives its filter_en and gain select, and observes its PI code output.

Parameters:
PI_BIT, 8, PI code width (code is modulo 2**PI_BIT)
SETTLE_CYC, 16, cycles filter held disabled before acquisition
ACQ_CYC, 64, cycles at gear 0 (highest gain)
GEAR_CYC, 32, cycles per intermediate gear
NUM_GEARS, 4, number of gain gears; kp_sel spans 0..NUM_GEARS-1
LOCK_WIN, 64, lock-detect window length in cycles
LOCK_TOL, 2, max drift span (codes) within a window to declare lock
UNLOCK_TOL, 6, drift span in a window above which lock is lost (UNLOCK_TOL >= LOCK_TOL)
TIMEOUT_WIN, 16, windows allowed in CHECK before fail (optional feature only)

Ports:
clk  input  1  loop clock, same as the loop filter clock
rst  input  1  synchronous, active-high reset
en  input  1  level: run sequencer; low returns to IDLE
pi_code  input  PI_BIT  loop filter output code, sampled every cycle
filter_en  output  1  to loop filter; 0 holds the filter at its offset
kp_sel  output  $clog2(NUM_GEARS)  gain gear; 0 = highest Kp
locked  output  1  lock indication
lock_lost  output  1  one-cycle pulse on LOCKED->ACQ transition
fail  output  1  acquisition timeout (optional feature)
state  output  3  current FSM state encoding, for debug

Behaviour:
- All outputs registered. Reset values: filter_en=0, kp_sel=0, locked=0, lock_lost=0, fail=0, state=IDLE.
- State encoding: IDLE=0, SETTLE=1, ACQ=2, GEAR=3, CHECK=4, LOCKED=5, FAIL=6.
- rst dominates everything.
- en low in any state -> IDLE next cycle; all counters and outputs return to reset values.

FSM transitions:
- IDLE: en=1 -> SETTLE; cycle counter cleared.
- SETTLE: filter_en=0, kp_sel=0. After exactly SETTLE_CYC cycles -> ACQ.
- ACQ: filter_en=1, kp_sel=0. After ACQ_CYC cycles:
  - NUM_GEARS>1 -> GEAR with kp_sel=1;
  - NUM_GEARS=1 -> CHECK.
- GEAR: every GEAR_CYC cycles kp_sel increments. The cycle that kp_sel would exceed NUM_GEARS-1 goes to CHECK instead; kp_sel stays at NUM_GEARS-1.
- CHECK: windowed drift measurement (below). At window end:
  - span <= LOCK_TOL -> LOCKED, locked=1;
  - otherwise start a new window, staying in CHECK.
- LOCKED: windows continue. At window end, span > UNLOCK_TOL -> ACQ; locked=0; lock_lost=1 for one cycle; kp_sel=0; filter_en stays 1 (no re-settle).

Drift measurement:
- delta = pi_code - pi_code_prev, computed mod 2**PI_BIT and interpreted signed in [-2**(PI_BIT-1), 2**(PI_BIT-1)-1]. Wrap 255->0 counts as +1.
- acc is signed, width PI_BIT+$clog2(LOCK_WIN)+1, no overflow possible; acc accumulates delta. The window tracks acc_min/acc_max.
- span = acc_max - acc_min.
- First cycle of each window: acc=0, min=max=0, pi_code_prev loaded, no delta applied. The window covers LOCK_WIN cycles, giving LOCK_WIN-1 deltas.
- pi_code is ignored outside CHECK/LOCKED.

Latency:
- en rise to filter_en=1: 1+SETTLE_CYC cycles.
- The decision at window end takes effect on the next cycle.

Optional Feature:
CDR_LF_SEQ_TIMEOUT_EN
- Defined:
  - a window counter runs in CHECK and is cleared on entry to CHECK;
  - after TIMEOUT_WIN consecutive failed windows -> FAIL: fail=1, filter_en=0, locked=0, kp_sel=0;
  - FAIL is held until en low or rst.
- Undefined:
  - FAIL is unreachable, fail is tied 0, TIMEOUT_WIN is unused;
  - CHECK retries forever.

Test Plan:
1. Params 8/4/8/8/3/16/2/6. rst, then en=1 at cycle 0 -> state SETTLE cycles 1-4, filter_en=1 from cycle 5, kp_sel=1 at cycle 13, kp_sel=2 at 21, CHECK at 29.
2. In CHECK, pi_code constant 0x40 -> span=0, locked=1 at window end (cycle 45); lock_lost=0.
3. pi_code toggling 254,255,0,1,0,255 repeatedly -> deltas ±1 across wrap, span=3 -> no lock (LOCK_TOL=2); same pattern limited to 255,0,255 -> span=1 -> lock.
4. While LOCKED, ramp pi_code +1/cycle for one window -> span=15 > 6 -> lock_lost pulse exactly 1 cycle, locked=0, kp_sel=0, state ACQ, filter_en stays 1.
5. en deasserted mid-GEAR (kp_sel=1) -> next cycle state IDLE, filter_en=0, kp_sel=0; rst asserted while LOCKED -> all outputs reset next edge.
6. With CDR_LF_SEQ_TIMEOUT_EN, TIMEOUT_WIN=3, pi_code ramping -> fail=1 after 3 windows in CHECK, filter_en=0; en low clears fail; without the macro, fail stays 0.
